// File: rtl/ball_ctrl.sv
// ball_ctrl: Pong ball controller. Moves the ball once per frame tick,
// bounces it off the top/bottom walls and the two paddles, detects goals,
// keeps both scores and freezes the game for a fixed number of frames
// after each goal.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   frame_tick_i           one-cycle pulse per frame (vblank start)
//   serve_i                serve request, honoured only while idle
//   player_paddle_x/y_i    left paddle top-left corner
//   pc_paddle_x/y_i        right paddle top-left corner
//   ball_x_o, ball_y_o     ball top-left corner (registered)
//   score_player_o/pc_o    saturating scores (registered)
//   in_play_o              high while the ball is live (registered)
//   goal_o                 one-cycle pulse when a goal is scored (registered)
module ball_ctrl #(
  parameter int unsigned X_POS_W     = 10,
  parameter int unsigned Y_POS_W     = 10,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIDE   = 8,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned SPEED_X     = 2,
  parameter int unsigned SPEED_Y     = 2,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned SCORE_W     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_tick_i,
  input  logic               serve_i,
  input  logic [X_POS_W-1:0] player_paddle_x_i,
  input  logic [Y_POS_W-1:0] player_paddle_y_i,
  input  logic [X_POS_W-1:0] pc_paddle_x_i,
  input  logic [Y_POS_W-1:0] pc_paddle_y_i,
  output logic [X_POS_W-1:0] ball_x_o,
  output logic [Y_POS_W-1:0] ball_y_o,
  output logic [SCORE_W-1:0] score_player_o,
  output logic [SCORE_W-1:0] score_pc_o,
  output logic               in_play_o,
  output logic               goal_o
);

  // Signed working widths: two spare bits so x-SPEED and x+SIDE never wrap.
  localparam int unsigned XS_W   = X_POS_W + 2;
  localparam int unsigned YS_W   = Y_POS_W + 2;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [X_POS_W-1:0] CX = X_POS_W'((SCREEN_W - BALL_SIDE) / 2);
  localparam logic [Y_POS_W-1:0] CY = Y_POS_W'((SCREEN_H - BALL_SIDE) / 2);

  localparam logic signed [XS_W-1:0] ZERO_X  = '0;
  localparam logic signed [YS_W-1:0] ZERO_Y  = '0;
  localparam logic signed [XS_W-1:0] SPD_X_S = XS_W'(SPEED_X);
  localparam logic signed [YS_W-1:0] SPD_Y_S = YS_W'(SPEED_Y);
  localparam logic signed [XS_W-1:0] BS_X_S  = XS_W'(BALL_SIDE);
  localparam logic signed [YS_W-1:0] BS_Y_S  = YS_W'(BALL_SIDE);
  localparam logic signed [XS_W-1:0] PW_S    = XS_W'(PADDLE_W);
  localparam logic signed [YS_W-1:0] PH_S    = YS_W'(PADDLE_H);
  localparam logic signed [XS_W-1:0] SCR_W_S = XS_W'(SCREEN_W);
  localparam logic signed [YS_W-1:0] SCR_H_S = YS_W'(SCREEN_H);
  localparam logic signed [YS_W-1:0] Y_MAX_S = YS_W'(SCREEN_H - BALL_SIDE);

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_SCORED = 2'd2
  } state_e;

  state_e             state_q;
  logic [X_POS_W-1:0] ball_x_q;
  logic [Y_POS_W-1:0] ball_y_q;
  logic               dir_x_q;   // 1 = moving right
  logic               dir_y_q;   // 1 = moving down
  logic [SCORE_W-1:0] score_player_q;
  logic [SCORE_W-1:0] score_pc_q;
  logic [HOLD_W-1:0]  hold_q;
  logic               in_play_q;
  logic               goal_q;

  // Candidate next values for a frame tick in PLAY.
  logic [X_POS_W-1:0] ball_x_d;
  logic [Y_POS_W-1:0] ball_y_d;
  logic               dir_x_d;
  logic               dir_y_d;
  logic               goal_pc_d;
  logic               goal_player_d;

  logic signed [XS_W-1:0] x_s, nx_s, pl_x_s, pl_edge_s, pc_x_s, pc_hit_s;
  logic signed [YS_W-1:0] y_s, ny_s, y_clamp_s, pl_y_s, pc_y_s;
  logic                   dir_y_new;
  logic                   v_pl, v_pc, hit_l, hit_r;

  // Per-tick motion: wall bounce, paddle hits, goal detection.
  always_comb begin
    x_s       = $signed({2'b00, ball_x_q});
    y_s       = $signed({2'b00, ball_y_q});
    pl_x_s    = $signed({2'b00, player_paddle_x_i});
    pc_x_s    = $signed({2'b00, pc_paddle_x_i});
    pl_y_s    = $signed({2'b00, player_paddle_y_i});
    pc_y_s    = $signed({2'b00, pc_paddle_y_i});
    pl_edge_s = pl_x_s + PW_S;
    pc_hit_s  = pc_x_s - BS_X_S;

    nx_s = dir_x_q ? (x_s + SPD_X_S) : (x_s - SPD_X_S);
    ny_s = dir_y_q ? (y_s + SPD_Y_S) : (y_s - SPD_Y_S);

    y_clamp_s = ny_s;
    dir_y_new = dir_y_q;
    if (!dir_y_q && (ny_s <= ZERO_Y)) begin
      y_clamp_s = ZERO_Y;
      dir_y_new = 1'b1;
    end else if (dir_y_q && ((ny_s + BS_Y_S) >= SCR_H_S)) begin
      y_clamp_s = Y_MAX_S;
      dir_y_new = 1'b0;
    end

    // Paddle overlap is judged on the already-clamped vertical position.
    v_pl = ((y_clamp_s + BS_Y_S) > pl_y_s) && (y_clamp_s < (pl_y_s + PH_S));
    v_pc = ((y_clamp_s + BS_Y_S) > pc_y_s) && (y_clamp_s < (pc_y_s + PH_S));

    // Hits require the ball to cross the paddle face during this step.
    hit_l = !dir_x_q && (x_s >= pl_edge_s) && (nx_s <= pl_edge_s) && v_pl;
    hit_r = dir_x_q && ((x_s + BS_X_S) <= pc_x_s) &&
            ((nx_s + BS_X_S) >= pc_x_s) && v_pc;

    goal_pc_d     = !hit_l && !hit_r && (nx_s < ZERO_X);
    goal_player_d = !hit_l && !hit_r && !goal_pc_d &&
                    ((nx_s + BS_X_S) > SCR_W_S);

    ball_x_d = nx_s[X_POS_W-1:0];
    ball_y_d = y_clamp_s[Y_POS_W-1:0];
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_new;
    if (hit_l) begin
      ball_x_d = pl_edge_s[X_POS_W-1:0];
      dir_x_d  = 1'b1;
    end else if (hit_r) begin
      ball_x_d = pc_hit_s[X_POS_W-1:0];
      dir_x_d  = 1'b0;
    end else if (goal_pc_d || goal_player_d) begin
      // Ball freezes where it was; next serve heads toward the conceding side.
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d  = goal_player_d;
      dir_y_d  = dir_y_q;
    end
  end

  // Game FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      ball_x_q       <= CX;
      ball_y_q       <= CY;
      dir_x_q        <= 1'b1;
      dir_y_q        <= 1'b1;
      score_player_q <= '0;
      score_pc_q     <= '0;
      hold_q         <= '0;
      in_play_q      <= 1'b0;
      goal_q         <= 1'b0;
    end else begin
      goal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (serve_i) begin
            state_q   <= ST_PLAY;
            in_play_q <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (frame_tick_i) begin
            ball_x_q <= ball_x_d;
            ball_y_q <= ball_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            if (goal_pc_d || goal_player_d) begin
              state_q   <= ST_SCORED;
              in_play_q <= 1'b0;
              goal_q    <= 1'b1;
              hold_q    <= '0;
              if (goal_pc_d && (score_pc_q != SCORE_MAX)) begin
                score_pc_q <= score_pc_q + SCORE_W'(1);
              end
              if (goal_player_d && (score_player_q != SCORE_MAX)) begin
                score_player_q <= score_player_q + SCORE_W'(1);
              end
            end
          end
        end
        ST_SCORED: begin
          if (frame_tick_i) begin
            if (hold_q == HOLD_LAST) begin
              state_q  <= ST_IDLE;
              hold_q   <= '0;
              ball_x_q <= CX;
              ball_y_q <= CY;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          in_play_q <= 1'b0;
        end
      endcase
    end
  end

  assign ball_x_o       = ball_x_q;
  assign ball_y_o       = ball_y_q;
  assign score_player_o = score_player_q;
  assign score_pc_o     = score_pc_q;
  assign in_play_o      = in_play_q;
  assign goal_o         = goal_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Testbench for ball_ctrl: a behavioural game model predicts every cycle's
// outputs; predictions are queued when stimulus is driven and compared once
// the clock edge has produced the DUT's registered outputs.
module tb_ball_ctrl;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int BS = 8;
  localparam int PW = 8;
  localparam int PH = 64;
  localparam int SP = 2;
  localparam int HOLD = 60;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       frame_tick_i = 1'b0;
  logic       serve_i = 1'b0;
  logic [9:0] pl_x = 10'd16, pl_y = 10'd200, pc_x = 10'd616, pc_y = 10'd200;
  logic [9:0] ball_x_o, ball_y_o;
  logic [3:0] score_player_o, score_pc_o;
  logic       in_play_o, goal_o;

  ball_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .frame_tick_i(frame_tick_i), .serve_i(serve_i),
    .player_paddle_x_i(pl_x), .player_paddle_y_i(pl_y),
    .pc_paddle_x_i(pc_x), .pc_paddle_y_i(pc_y),
    .ball_x_o(ball_x_o), .ball_y_o(ball_y_o),
    .score_player_o(score_player_o), .score_pc_o(score_pc_o),
    .in_play_o(in_play_o), .goal_o(goal_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  logic [29:0] exp_q[$];
  bit goal_seen;

  // Model state: 0 idle, 1 play, 2 scored.
  int m_st, m_bx, m_by, m_sp, m_sc, m_hold;
  bit m_dxr, m_dyd, m_goal;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_bx = 316; m_by = 236; m_dxr = 1; m_dyd = 1;
    m_sp = 0; m_sc = 0; m_hold = 0; m_goal = 0;
  endtask

  task automatic model_cycle(input logic s, input logic t);
    int nx, ny, yy, plx, ply, pcx, pcy;
    bit ndy, vp, vc;
    m_goal = 0;
    case (m_st)
      0: if (s) m_st = 1;
      1: if (t) begin
        plx = int'(pl_x); ply = int'(pl_y); pcx = int'(pc_x); pcy = int'(pc_y);
        nx = m_dxr ? m_bx + SP : m_bx - SP;
        ny = m_dyd ? m_by + SP : m_by - SP;
        yy = ny; ndy = m_dyd;
        if (!m_dyd && ny <= 0) begin yy = 0; ndy = 1; end
        else if (m_dyd && ny + BS >= SH) begin yy = SH - BS; ndy = 0; end
        vp = (yy + BS > ply) && (yy < ply + PH);
        vc = (yy + BS > pcy) && (yy < pcy + PH);
        if (!m_dxr && m_bx >= plx + PW && nx <= plx + PW && vp) begin
          m_bx = plx + PW; m_dxr = 1; m_by = yy; m_dyd = ndy;
        end else if (m_dxr && m_bx + BS <= pcx && nx + BS >= pcx && vc) begin
          m_bx = pcx - BS; m_dxr = 0; m_by = yy; m_dyd = ndy;
        end else if (nx < 0) begin
          m_sc = (m_sc < 15) ? m_sc + 1 : 15;
          m_goal = 1; m_st = 2; m_hold = 0; m_dxr = 0;
        end else if (nx + BS > SW) begin
          m_sp = (m_sp < 15) ? m_sp + 1 : 15;
          m_goal = 1; m_st = 2; m_hold = 0; m_dxr = 1;
        end else begin
          m_bx = nx; m_by = yy; m_dyd = ndy;
        end
      end
      default: if (t) begin
        m_hold++;
        if (m_hold == HOLD) begin m_st = 0; m_bx = 316; m_by = 236; end
      end
    endcase
  endtask

  function automatic logic [29:0] model_vec();
    return {10'(m_bx), 10'(m_by), 4'(m_sp), 4'(m_sc), (m_st == 1), m_goal};
  endfunction

  function automatic logic [29:0] dut_vec();
    return {ball_x_o, ball_y_o, score_player_o, score_pc_o, in_play_o, goal_o};
  endfunction

  // One clock cycle: drive, predict, then compare after the edge.
  task automatic step(input logic s, input logic t);
    logic [29:0] e;
    @(negedge clk_i);
    serve_i = s; frame_tick_i = t;
    model_cycle(s, t);
    exp_q.push_back(model_vec());
    @(posedge clk_i); #1;
    serve_i = 1'b0; frame_tick_i = 1'b0;
    if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("cycle", 32'(dut_vec()), 32'(e));
    end
    if (goal_o) goal_seen = 1;
  endtask

  task automatic frame();
    step(1'b0, 1'b1);
    repeat ($urandom_range(0, 2)) step(1'b0, 1'b0);
  endtask

  function automatic logic [9:0] track(input int by, input int off);
    int v = by - off;
    if (v < 0) v = 0;
    return 10'(v);
  endfunction

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (m_st != 0 && n < 800) begin
      if (m_st == 1) pc_y = track(m_by, 20);
      frame();
      n++;
    end
    check(tag, 32'(in_play_o), 32'd0);
  endtask

  task automatic sync_reset();
    @(negedge clk_i); rst_i = 1'b1;
    model_reset();
    step(1'b0, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;
  endtask

  localparam logic [29:0] RESET_VEC = {10'd316, 10'd236, 4'd0, 4'd0, 1'b0, 1'b0};

  initial begin
    model_reset();
    goal_seen = 0;
    repeat (2) @(posedge clk_i);
    #1 check("reset_vals", 32'(dut_vec()), 32'(RESET_VEC));
    @(negedge clk_i); rst_i = 1'b0;

    // Idle: ticks ignored, serve starts play, first tick moves right/down.
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("idle_tick_x", 32'(ball_x_o), 32'd316);
    step(1'b1, 1'b0);
    check("serve_in_play", 32'(in_play_o), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("first_tick_xy", {12'd0, ball_x_o, ball_y_o}, {12'd0, 10'd318, 10'd238});
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("held_between_ticks", 32'(ball_x_o), 32'd318);

    // Serve and tick together in idle: play starts, no motion.
    sync_reset();
    step(1'b1, 1'b1);
    check("serve_tick_same", {11'd0, in_play_o, ball_x_o, ball_y_o}, {11'd0, 1'b1, 10'd316, 10'd236});

    // Rally: paddles loosely track the ball, sometimes missing on purpose.
    pl_x = 10'd16; pc_x = 10'd616;
    for (int i = 0; i < 1500; i++) begin
      if (m_st == 0) step(1'b1, 1'b0);
      pl_y = ($urandom_range(0, 5) == 0) ? 10'((m_by + 200) % 420) : track(m_by, $urandom_range(0, 60));
      pc_y = ($urandom_range(0, 5) == 0) ? 10'((m_by + 200) % 420) : track(m_by, $urandom_range(0, 60));
      frame();
    end

    // Saturation: pc paddle returns the first serve, the player never hits.
    sync_reset();
    pl_x = 10'd1000; pc_x = 10'd616;
    step(1'b1, 1'b0);
    run_until_idle("idle_after_goal1");
    check("pc_score_1", {score_player_o, score_pc_o}, {4'd0, 4'd1});
    check("centre_after_hold", {12'd0, ball_x_o, ball_y_o}, {12'd0, 10'd316, 10'd236});
    pc_x = 10'd0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("serve_toward_loser", 32'(ball_x_o), 32'd314);
    run_until_idle("idle_after_goal2");
    for (int g = 3; g <= 15; g++) begin
      step(1'b1, 1'b0);
      run_until_idle("idle_after_goal_n");
    end
    check("pc_score_15", 32'(score_pc_o), 32'd15);
    goal_seen = 0;
    step(1'b1, 1'b0);
    run_until_idle("idle_after_sat");
    check("pc_score_sat", 32'(score_pc_o), 32'd15);
    check("sat_goal_pulse", 32'(goal_seen), 32'd1);

    // Asynchronous reset between edges during play.
    pl_x = 10'd16; pc_x = 10'd616;
    step(1'b1, 1'b0);
    repeat (5) frame();
    #2 rst_i = 1'b1;
    #1 check("async_reset", 32'(dut_vec()), 32'(RESET_VEC));
    model_reset();
    step(1'b0, 1'b0);
    @(negedge clk_i); rst_i = 1'b0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("serve_after_reset", {12'd0, ball_x_o, ball_y_o}, {12'd0, 10'd318, 10'd238});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ball_ctrl.md
BALL_CTRL -- requirements
Module: ball_ctrl

Interface
REQ-001 SHALL have parameter X_POS_W, default 10, width of X coordinates.
REQ-002 SHALL have parameter Y_POS_W, default 10, width of Y coordinates.
REQ-003 SHALL have parameters SCREEN_W 640 and SCREEN_H 480, visible area in pixels.
REQ-004 SHALL have parameter BALL_SIDE, default 8, ball square side.
REQ-005 SHALL have parameters PADDLE_W 8 and PADDLE_H 64, paddle size (both paddles).
REQ-006 SHALL have parameters SPEED_X 2 and SPEED_Y 2, pixels moved per frame per axis.
REQ-007 SHALL have parameters HOLD_FRAMES 60 (post-goal freeze) and SCORE_W 4 (score width).
REQ-008 Ports SHALL be: clk_i  in  1  system clock; rst_i  in  1  reset.
REQ-009 SHALL use one clock, clk_i; rst_i SHALL be asynchronous and active-high.
REQ-010 Ports: frame_tick_i  in  1  one-cycle pulse per frame, at vblank start.
REQ-011 Ports: serve_i  in  1  level/pulse, request serve.
REQ-012 Ports: player_paddle_x_i/_y_i  in  X_POS_W/Y_POS_W  left paddle top-left corner.
REQ-013 Ports: pc_paddle_x_i/_y_i  in  X_POS_W/Y_POS_W  right paddle top-left corner.
REQ-014 Ports: ball_x_o/ball_y_o  out  X_POS_W/Y_POS_W  ball top-left corner, registered.
REQ-015 Ports: score_player_o/score_pc_o  out  SCORE_W  scores; in_play_o  out  1; goal_o  out  1  one-cycle pulse.

Function
REQ-016 SHALL implement FSM IDLE, PLAY, SCORED; all outputs registered.
REQ-017 IDLE: ball held at centre CX=(SCREEN_W-BALL_SIDE)/2, CY=(SCREEN_H-BALL_SIDE)/2; serve_i=1 -> PLAY next cycle; frame_tick_i ignored.
REQ-018 PLAY: position updates only on cycles with frame_tick_i=1; otherwise held.
REQ-019 On tick: nx=x+/-SPEED_X, ny=y+/-SPEED_Y per dir_x/dir_y, computed signed at width+2 bits (no wrap).
REQ-020 Vertical: dir up and ny<=0 -> y=0, dir_y=down; dir down and ny+BALL_SIDE>=SCREEN_H -> y=SCREEN_H-BALL_SIDE, dir_y=up; else y=ny.
REQ-021 Vertical overlap V with a paddle: (ny+BALL_SIDE > pad_y) and (ny < pad_y+PADDLE_H), using post-clamp y.
REQ-022 Left hit: dir left, x>=player_x+PADDLE_W, nx<=player_x+PADDLE_W, V -> x=player_x+PADDLE_W, dir_x=right.
REQ-023 Right hit: dir right, x+BALL_SIDE<=pc_x, nx+BALL_SIDE>=pc_x, V -> x=pc_x-BALL_SIDE, dir_x=left.
REQ-024 Goal: no hit and nx<0 -> pc scores; no hit and nx+BALL_SIDE>SCREEN_W -> player scores; ball position frozen at pre-tick value.
REQ-025 Otherwise x=nx; paddle checks take priority over goal checks.
REQ-026 On goal: scorer's count +1, saturating at 2^SCORE_W-1; goal_o=1 for one cycle; FSM -> SCORED.
REQ-027 SCORED: count HOLD_FRAMES frame ticks, then -> IDLE with ball at centre and dir_x toward the conceding side; dir_y kept.
REQ-028 in_play_o=1 exactly in PLAY.
REQ-029 serve_i outside IDLE SHALL be ignored; serve_i and frame_tick_i same cycle in IDLE -> PLAY, no motion that tick.

Reset
REQ-030 rst_i=1 SHALL immediately force: IDLE, ball (CX,CY)=(316,236), dir_x=right, dir_y=down, scores 0, goal_o=0, in_play_o=0, hold counter 0.
REQ-031 Reset mid-PLAY or mid-SCORED SHALL discard all game state; first serve after release SHALL move right/down.

Verification
REQ-032 Reset, serve pulse, one tick -> ball (318,238), in_play_o=1; no change between ticks.
REQ-033 Ball y=1 moving up, tick -> y=0, dir down; next tick -> y=2.
REQ-034 Player paddle (16,200), ball (26,220) moving left/down, tick -> x=24, y=222, dir_x right; next tick x=26.
REQ-035 Ball x=1 moving left, player paddle y=0, ball y=300, tick -> goal_o 1 cycle, score_pc_o=1, ball frozen 60 ticks, then IDLE at (316,236); next serve moves left.
REQ-036 score_pc_o=15, another pc goal -> stays 15, goal_o still pulses.
REQ-037 Assert rst_i asynchronously mid-PLAY between clock edges -> outputs at reset values before next edge.
